nrzi_decoder: RTL and testbench

Receive-side counterpart of the toggle flip-flop: recovers data from a line driven by a T flip-flop used as an NRZI encoder, where each data bit 1 toggles the line and each data bit 0 holds it. On every bit strobe the block compares the sampled line against the last tracked level, removes stuffed bits and assembles WIDTH-bit words LSB first. It sits between the serial line (or a `tflipflop` encoder in loopback) and any parallel consumer.

---
 rtl/nrzi_decoder_if.sv | 23 ++
 rtl/nrzi_decoder.sv | 123 ++++++++++++
 tb/tb_nrzi_decoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/nrzi_decoder_if.sv
// Parallel-side bundle of the NRZI decoder. The consumer/driver holds the master
// modport and the decoder holds the slave modport.
interface nrzi_decoder_if #(
  parameter int WIDTH = 8
);
  logic             En;
  logic             Load;
  logic             Din;
  logic [WIDTH-1:0] Dout;
  logic             Valid;
  logic             StuffErr;
  logic             Level;

  modport master (
    output En, Load, Din,
    input  Dout, Valid, StuffErr, Level
  );

  modport slave (
    input  En, Load, Din,
    output Dout, Valid, StuffErr, Level
  );
endinterface

// File: rtl/nrzi_decoder.sv
// NRZI receiver for a toggle-encoded line: decodes line transitions into bits,
// removes stuffed zeros and assembles LSB-first words.
module nrzi_decoder #(
  parameter int WIDTH     = 8,
  parameter int STUFF_LEN = 6
) (
  input logic            Clk,
  input logic            Res,
  nrzi_decoder_if.slave  bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int OW = (STUFF_LEN > 1) ? $clog2(STUFF_LEN + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [OW-1:0] STUFF_CNT = OW'(STUFF_LEN);

  typedef enum logic {
    ST_DATA  = 1'b0,
    ST_STUFF = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             level_q, level_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [OW-1:0]    ones_q, ones_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             stufferr_q, stufferr_d;

  logic             bit_s;
  logic [WIDTH-1:0] shifted_s;
  logic [OW-1:0]    ones_inc_s;

  assign bit_s      = bus.Din ^ level_q;
  assign shifted_s  = {bit_s, sr_q};
  assign ones_inc_s = bit_s ? (ones_q + OW'(1)) : {OW{1'b0}};

  // Next-state decode: Load resynchronises, En decodes one bit, otherwise hold.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    sr_d       = sr_q;
    bitcnt_d   = bitcnt_q;
    ones_d     = ones_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    stufferr_d = 1'b0;
    if (bus.Load) begin
      level_d  = bus.Din;
      sr_d     = {(WIDTH-1){1'b0}};
      bitcnt_d = {BW{1'b0}};
      ones_d   = {OW{1'b0}};
      state_d  = ST_DATA;
    end else if (bus.En) begin
      level_d = bus.Din;
      case (state_q)
        ST_DATA: begin
          sr_d   = shifted_s[WIDTH-1:1];
          ones_d = ones_inc_s;
          if (bitcnt_q == LAST_BIT) begin
            dout_d   = shifted_s;
            valid_d  = 1'b1;
            bitcnt_d = {BW{1'b0}};
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
          // The ones run spans word boundaries, so this is checked independently of word completion.
          if ((STUFF_LEN > 0) && (ones_inc_s == STUFF_CNT)) begin
            state_d = ST_STUFF;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_STUFF: begin
          ones_d  = {OW{1'b0}};
          state_d = ST_DATA;
          if (bit_s) begin
            stufferr_d = 1'b1;
            sr_d       = {(WIDTH-1){1'b0}};
            bitcnt_d   = {BW{1'b0}};
          end else begin
            stufferr_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_DATA;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Res) begin
      state_q    <= ST_DATA;
      level_q    <= 1'b0;
      sr_q       <= {(WIDTH-1){1'b0}};
      bitcnt_q   <= {BW{1'b0}};
      ones_q     <= {OW{1'b0}};
      dout_q     <= {WIDTH{1'b0}};
      valid_q    <= 1'b0;
      stufferr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      sr_q       <= sr_d;
      bitcnt_q   <= bitcnt_d;
      ones_q     <= ones_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      stufferr_q <= stufferr_d;
    end
  end

  assign bus.Dout     = dout_q;
  assign bus.Valid    = valid_q;
  assign bus.StuffErr = stufferr_q;
  assign bus.Level    = level_q;

endmodule

// File: tb/tb_nrzi_decoder.sv
// Directed bench for nrzi_decoder (WIDTH=8, STUFF_LEN=6): drives NRZI line
// levels strobe by strobe and checks Valid/StuffErr/Dout/Level after each edge.
module tb_nrzi_decoder;

  logic clk = 1'b0;
  logic res = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic tb_lvl = 1'b0;
  int   tb_ones = 0;

  nrzi_decoder_if #(.WIDTH(8)) bus ();

  nrzi_decoder #(.WIDTH(8), .STUFF_LEN(6)) dut (
    .Clk (clk),
    .Res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe with line level d; checks the outputs one step after the edge.
  task automatic strobe(input logic d, input logic exp_v, input logic exp_e, input string tag);
    @(negedge clk);
    bus.En   = 1'b1;
    bus.Load = 1'b0;
    bus.Din  = d;
    @(posedge clk);
    #1;
    tb_lvl = d;
    chk({tag, ".valid"}, 32'(bus.Valid), 32'(exp_v));
    chk({tag, ".stufferr"}, 32'(bus.StuffErr), 32'(exp_e));
    chk({tag, ".level"}, 32'(bus.Level), 32'(d));
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    bus.En   = 1'b0;
    bus.Load = 1'b0;
    bus.Din  = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    chk({tag, ".idle_valid"}, 32'(bus.Valid), 32'd0);
    chk({tag, ".idle_stufferr"}, 32'(bus.StuffErr), 32'd0);
    chk({tag, ".idle_level"}, 32'(bus.Level), 32'(tb_lvl));
  endtask

  task automatic load(input logic d, input logic en, input string tag);
    @(negedge clk);
    bus.En   = en;
    bus.Load = 1'b1;
    bus.Din  = d;
    @(posedge clk);
    #1;
    tb_lvl  = d;
    tb_ones = 0;
    chk({tag, ".load_level"}, 32'(bus.Level), 32'(d));
    chk({tag, ".load_valid"}, 32'(bus.Valid), 32'd0);
    chk({tag, ".load_stufferr"}, 32'(bus.StuffErr), 32'd0);
  endtask

  // Encodes one word LSB first with an inserted zero after every six ones.
  task automatic send_word(input logic [7:0] data, input bit gaps, input string tag);
    for (int i = 0; i < 8; i++) begin
      strobe(tb_lvl ^ data[i], (i == 7), 1'b0, tag);
      tb_ones = data[i] ? tb_ones + 1 : 0;
      if (tb_ones == 6) begin
        strobe(tb_lvl, 1'b0, 1'b0, {tag, ".stuffbit"});
        tb_ones = 0;
      end
      if (gaps) begin
        repeat ($urandom_range(1, 3)) idle({tag, ".gap"});
      end
    end
    chk({tag, ".dout"}, 32'(bus.Dout), 32'(data));
  endtask

  initial begin
    logic [7:0] pat_basic;
    logic [8:0] pat_stuff;
    logic [6:0] pat_err;
    logic [5:0] pat_six;

    bus.En   = 1'b0;
    bus.Load = 1'b0;
    bus.Din  = 1'b0;

    // Reset held for two edges with random strobes.
    repeat (2) begin
      @(negedge clk);
      bus.En  = 1'($urandom_range(0, 1));
      bus.Din = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    chk("reset.level", 32'(bus.Level), 32'd0);
    chk("reset.dout", 32'(bus.Dout), 32'h00);
    chk("reset.valid", 32'(bus.Valid), 32'd0);
    chk("reset.stufferr", 32'(bus.StuffErr), 32'd0);
    @(negedge clk);
    res    = 1'b1;
    bus.En = 1'b0;
    tb_lvl = 1'b0;
    idle("post_reset");

    // Din 1,1,0,0,0,1,1,0 from level 0 -> data 0xA5.
    pat_basic = 8'b0110_0011;
    for (int i = 0; i < 8; i++) strobe(pat_basic[i], (i == 7), 1'b0, "basic");
    chk("basic.dout", 32'(bus.Dout), 32'hA5);
    chk("basic.level", 32'(bus.Level), 32'd0);
    idle("basic");
    chk("basic.dout_held", 32'(bus.Dout), 32'hA5);

    // Six ones, stuffed zero, two ones -> one word 0xFF after the 9th strobe.
    load(1'b0, 1'b0, "stuff");
    pat_stuff = 9'b0_1001_0101;
    for (int i = 0; i < 9; i++) strobe(pat_stuff[i], (i == 8), 1'b0, "stuff");
    chk("stuff.dout", 32'(bus.Dout), 32'hFF);
    idle("stuff");

    // Seventh consecutive toggle is a stuffing violation.
    load(1'b0, 1'b0, "stufferr");
    pat_err = 7'b101_0101;
    for (int i = 0; i < 7; i++) strobe(pat_err[i], 1'b0, (i == 6), "stufferr");
    chk("stufferr.dout_kept", 32'(bus.Dout), 32'hFF);
    idle("stufferr");
    tb_ones = 0;
    send_word(8'hA5, 1'b0, "after_err");

    // Ones run crossing a word boundary forces a stuffed bit inside the next word.
    send_word(8'hF0, 1'b0, "cross_a");
    send_word(8'h03, 1'b0, "cross_b");

    // Load mid-word discards three bits and resynchronises to level 1.
    for (int i = 0; i < 3; i++) strobe(tb_lvl, 1'b0, 1'b0, "partial");
    tb_ones = 0;
    load(1'b1, 1'b0, "resync");
    chk("resync.dout_kept", 32'(bus.Dout), 32'h03);
    send_word(8'h3C, 1'b0, "resync_word");

    // Load together with En: the opposite level must not decode as a bit.
    load(~tb_lvl, 1'b1, "load_en");
    chk("load_en.dout_kept", 32'(bus.Dout), 32'h3C);
    send_word(8'h81, 1'b0, "load_en_word");

    // Gapped strobes produce the same word with a single-cycle Valid.
    send_word(8'hA5, 1'b1, "gapped");
    idle("gapped_end");

    // Load while a stuffed bit is pending drops the expectation.
    load(1'b0, 1'b0, "stuff_drop");
    pat_six = 6'b01_0101;
    for (int i = 0; i < 6; i++) strobe(pat_six[i], 1'b0, 1'b0, "stuff_drop");
    load(1'b1, 1'b0, "stuff_drop2");
    strobe(1'b0, 1'b0, 1'b0, "stuff_drop_bit");

    // Reset mid-word clears Dout and Level.
    @(negedge clk);
    res    = 1'b0;
    bus.En = 1'b0;
    @(posedge clk);
    #1;
    chk("reset2.dout", 32'(bus.Dout), 32'h00);
    chk("reset2.level", 32'(bus.Level), 32'd0);
    chk("reset2.valid", 32'(bus.Valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
